// File: rtl/tpu_pkg.sv
// Shared types and pin-map constants for the TPU host driver.
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_DONE,
        CAPTURE
    } state_t;

    localparam int NUM_BYTES      = 8;
    localparam int UIO_LOAD_EN    = 0;
    localparam int UIO_TRANSPOSE  = 1;
    localparam int UIO_ACTIVATION = 2;
    localparam int UIO_DONE       = 7;

endpackage

// File: rtl/tpu_byte_deser.sv
// Collects result bytes into a shadow register and publishes
// all four 16-bit results together once the last byte arrives.
module tpu_byte_deser
    import tpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        last,
    output logic        result_valid,
    output logic [15:0] c00,
    output logic [15:0] c01,
    output logic [15:0] c10,
    output logic [15:0] c11
);

    localparam int CW = $clog2(NUM_BYTES);
    localparam int SW = 8 * (NUM_BYTES - 1);
    localparam logic [CW-1:0] C_LAST = CW'(NUM_BYTES - 1);

    logic [CW-1:0] cnt;
    logic [SW-1:0] shadow;

    assign last = (cnt == C_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            shadow       <= '0;
            result_valid <= 1'b0;
            c00          <= '0;
            c01          <= '0;
            c10          <= '0;
            c11          <= '0;
        end else begin
            result_valid <= 1'b0;
            if (shift_en) begin
                shadow <= {shadow[SW-9:0], byte_in};
                cnt    <= cnt + 1'b1;
                // First byte received lands in c00[15:8]
                if (last) begin
                    {c00, c01, c10, c11} <= {shadow, byte_in};
                    result_valid         <= 1'b1;
                    cnt                  <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/tpu_host_driver.sv
// Host-side master for the 2x2 systolic TPU: serialises operands,
// waits for done with a timeout, then reads back four results.
module tpu_host_driver
    import tpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int NUM_BYTES      = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] weights,
    input  logic [31:0] inputs,
    input  logic        transpose_req,
    input  logic        relu_req,
    output logic        busy,
    output logic        result_valid,
    output logic        timeout_err,
    output logic [15:0] c00,
    output logic [15:0] c01,
    output logic [15:0] c10,
    output logic [15:0] c11,
    output logic [7:0]  tpu_ui_in,
    output logic [7:0]  tpu_uio_in,
    input  logic [7:0]  tpu_uo_out,
    input  logic        tpu_done
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int KW = $clog2(NUM_BYTES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [KW-1:0] K_LAST = KW'(NUM_BYTES - 1);

    state_t                 state;
    state_t                 state_n;
    logic [KW-1:0]          k;
    logic [TW-1:0]          wait_cnt;
    logic [8*NUM_BYTES-1:0] ops;
    logic                   transpose_q;
    logic                   relu_q;
    logic                   shift_en;
    logic                   deser_last;
    logic                   timeout_hit;

    always_comb begin
        state_n     = state;
        shift_en    = 1'b0;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = LOAD;
            end
            LOAD: begin
                if (k == K_LAST) state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                // done wins over an expiring timeout in the same cycle
                if (tpu_done) begin
                    shift_en = 1'b1;
                    state_n  = CAPTURE;
                end else if (wait_cnt == T_LAST) begin
                    timeout_hit = 1'b1;
                    state_n     = IDLE;
                end
            end
            CAPTURE: begin
                shift_en = 1'b1;
                if (deser_last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            wait_cnt    <= '0;
            ops         <= '0;
            transpose_q <= 1'b0;
            relu_q      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            timeout_err <= timeout_hit;
            k           <= (state == LOAD) ? k + 1'b1 : '0;
            wait_cnt    <= (state == WAIT_DONE) ? wait_cnt + 1'b1 : '0;
            if (state == IDLE && start) begin
                ops         <= {inputs, weights};
                transpose_q <= transpose_req;
                relu_q      <= relu_req;
            end
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        tpu_ui_in  = '0;
        tpu_uio_in = '0;
        if (state == LOAD) tpu_ui_in = ops[{k, 3'b000} +: 8];
        tpu_uio_in[UIO_LOAD_EN]    = (state == LOAD);
        tpu_uio_in[UIO_TRANSPOSE]  = busy & transpose_q;
        tpu_uio_in[UIO_ACTIVATION] = busy & relu_q;
    end

    tpu_byte_deser u_deser (
        .clk          (clk),
        .rst          (rst),
        .shift_en     (shift_en),
        .byte_in      (tpu_uo_out),
        .last         (deser_last),
        .result_valid (result_valid),
        .c00          (c00),
        .c01          (c01),
        .c10          (c10),
        .c11          (c11)
    );

endmodule

// File: tb/tb_tpu_host_driver.sv
// Directed scoreboard bench for tpu_host_driver with a cycle-driven
// TPU pin model inside the stimulus sequence.
module tb_tpu_host_driver;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] weights;
    logic [31:0] inputs;
    logic        transpose_req;
    logic        relu_req;
    logic        busy;
    logic        result_valid;
    logic        timeout_err;
    logic [15:0] c00, c01, c10, c11;
    logic [7:0]  tpu_ui_in;
    logic [7:0]  tpu_uio_in;
    logic [7:0]  tpu_uo_out;
    logic        tpu_done;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] sb[$];
    logic [63:0] prev_c;

    tpu_host_driver #(.TIMEOUT_CYCLES(TMO), .NUM_BYTES(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .weights       (weights),
        .inputs        (inputs),
        .transpose_req (transpose_req),
        .relu_req      (relu_req),
        .busy          (busy),
        .result_valid  (result_valid),
        .timeout_err   (timeout_err),
        .c00           (c00),
        .c01           (c01),
        .c10           (c10),
        .c11           (c11),
        .tpu_ui_in     (tpu_ui_in),
        .tpu_uio_in    (tpu_uio_in),
        .tpu_uo_out    (tpu_uo_out),
        .tpu_done      (tpu_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference product C = I x W on signed bytes, packed as readback order
    function automatic logic [63:0] matmul(input logic [31:0] w, input logic [31:0] x);
        logic signed [15:0] a0, a1, a2, a3, b0, b1, b2, b3;
        logic [15:0] r00, r01, r10, r11;
        a0 = 16'(signed'(x[7:0]));   a1 = 16'(signed'(x[15:8]));
        a2 = 16'(signed'(x[23:16])); a3 = 16'(signed'(x[31:24]));
        b0 = 16'(signed'(w[7:0]));   b1 = 16'(signed'(w[15:8]));
        b2 = 16'(signed'(w[23:16])); b3 = 16'(signed'(w[31:24]));
        r00 = 16'(a0 * b0 + a1 * b2);
        r01 = 16'(a0 * b1 + a1 * b3);
        r10 = 16'(a2 * b0 + a3 * b2);
        r11 = 16'(a2 * b1 + a3 * b3);
        return {r00, r01, r10, r11};
    endfunction

    // d < 0 means the TPU never raises done
    task automatic run_job(input logic [31:0] w, input logic [31:0] x,
                           input logic tr, input logic re, input int d,
                           input logic [63:0] rb, input logic early,
                           input logic extra);
        logic [63:0] ops;
        logic [7:0]  mode;
        logic [63:0] exp;
        bit          got;
        ops  = {x, w};
        mode = {5'd0, re, tr, 1'b0};
        weights = w; inputs = x;
        transpose_req = tr; relu_req = re;
        start = 1'b1;
        if (d >= 0) sb.push_back(rb);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("load_byte", 64'(tpu_ui_in), 64'(ops[8*k +: 8]));
            chk("load_uio", 64'(tpu_uio_in), 64'(mode | 8'h01));
            chk("load_busy", 64'(busy), 64'd1);
            tpu_done = early;
            start = extra && (k == 3);
            @(negedge clk);
        end
        start = 1'b0;
        tpu_done = 1'b0;
        got = 0;
        for (int j = 0; j < TMO; j++) begin
            chk("wait_ui", 64'(tpu_ui_in), 64'd0);
            chk("wait_uio", 64'(tpu_uio_in), 64'(mode));
            chk("wait_busy", 64'(busy), 64'd1);
            if (j == d) begin
                tpu_done = 1'b1;
                tpu_uo_out = rb[63 -: 8];
                @(negedge clk);
                tpu_done = 1'b0;
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            chk("timeout_err", 64'(timeout_err), 64'd1);
            chk("timeout_busy", 64'(busy), 64'd0);
            chk("timeout_rv", 64'(result_valid), 64'd0);
            chk("timeout_uio", 64'(tpu_uio_in), 64'd0);
            chk("timeout_hold", {c00, c01, c10, c11}, prev_c);
            @(negedge clk);
            chk("timeout_pulse", 64'(timeout_err), 64'd0);
            return;
        end
        for (int b = 1; b < 8; b++) begin
            chk("cap_uio", 64'(tpu_uio_in), 64'(mode));
            chk("cap_busy", 64'(busy), 64'd1);
            chk("cap_rv", 64'(result_valid), 64'd0);
            tpu_uo_out = rb[63-8*b -: 8];
            start = extra && (b == 4);
            @(negedge clk);
        end
        start = 1'b0;
        tpu_uo_out = 8'hAA;
        chk("rv", 64'(result_valid), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_uio", 64'(tpu_uio_in), 64'd0);
        chk("done_err", 64'(timeout_err), 64'd0);
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            exp = sb.pop_front();
            chk("result", {c00, c01, c10, c11}, exp);
            prev_c = exp;
        end
        @(negedge clk);
        chk("rv_pulse", 64'(result_valid), 64'd0);
        chk("result_hold", {c00, c01, c10, c11}, prev_c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rb;
        rst = 1'b1; start = 1'b0;
        weights = '0; inputs = '0;
        transpose_req = 1'b0; relu_req = 1'b0;
        tpu_uo_out = 8'hAA; tpu_done = 1'b0;
        prev_c = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ui", 64'(tpu_ui_in), 64'd0);
        chk("rst_uio", 64'(tpu_uio_in), 64'd0);
        chk("rst_rv", 64'(result_valid), 64'd0);
        chk("rst_err", 64'(timeout_err), 64'd0);
        chk("rst_c", {c00, c01, c10, c11}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // basic job, done three cycles into WAIT_DONE
        rb = matmul(32'h08070605, 32'h04030201);
        chk("model_c", rb, {16'd19, 16'd22, 16'd43, 16'd50});
        run_job(32'h08070605, 32'h04030201, 1'b0, 1'b0, 3, rb, 1'b0, 1'b0);

        // both mode bits, signed operands
        rb = matmul(32'hFE037F80, 32'h81FF0210);
        run_job(32'hFE037F80, 32'h81FF0210, 1'b1, 1'b1, 0, rb, 1'b0, 1'b0);

        // start pulses while busy are dropped
        rb = matmul(32'h11223344, 32'h55667788);
        run_job(32'h11223344, 32'h55667788, 1'b1, 1'b0, 2, rb, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_rv", 64'(result_valid), 64'd0);
            @(negedge clk);
        end

        // TPU never answers
        run_job(32'h01010101, 32'h02020202, 1'b0, 1'b1, -1, 64'd0, 1'b0, 1'b0);

        // done held high in IDLE and LOAD is ignored
        tpu_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("early_busy", 64'(busy), 64'd0);
        end
        rb = 64'hFFFE_8000_7FFF_0001;
        run_job(32'h0A0B0C0D, 32'h01020304, 1'b0, 1'b0, 5, rb, 1'b1, 1'b0);
        chk("c00", 64'(c00), 64'hFFFE);
        chk("c11", 64'(c11), 64'h0001);

        // reset in LOAD at k=4 aborts the job
        weights = 32'hDDCCBBAA; inputs = 32'h44332211;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_k4", 64'(tpu_ui_in), 64'h11);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ui", 64'(tpu_ui_in), 64'd0);
        chk("abort_uio", 64'(tpu_uio_in), 64'd0);
        chk("abort_rv", 64'(result_valid), 64'd0);
        chk("abort_c", {c00, c01, c10, c11}, 64'd0);
        rst = 1'b0;
        prev_c = '0;
        @(negedge clk);
        rb = matmul(32'h05060708, 32'h0102FF03);
        run_job(32'h05060708, 32'h0102FF03, 1'b0, 1'b0, 1, rb, 1'b0, 1'b0);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
